// File: rtl/seq_scan_ctrl.sv
// Serial pattern scanner: accepts a word, shifts it out MSB first through a
// 4-bit window and counts matches against a programmable pattern.
//
// state | meaning
// IDLE  | ready for a word; configuration writes accepted
// SHIFT | shifting the captured word one bit per clock
module seq_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_pattern,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              irq,
    input  logic              irq_clr,
    output logic              cfg_err
);

    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] WORD_LD = CW'(WORD_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] shreg, shreg_nxt;
    logic [CW-1:0]     remain, remain_nxt;
    logic [3:0]        window, window_nxt;
    logic [2:0]        fill, fill_nxt;
    logic [3:0]        pattern, pattern_nxt;
    logic [CNT_W-1:0]  thresh, thresh_nxt;
    logic [CNT_W-1:0]  cnt_nxt, cnt_inc;
    logic              irq_nxt;
    logic              cfg_err_nxt;
    logic              match_fire;
    logic [3:0]        win_shift;
    logic [2:0]        fill_inc;

    assign in_ready = (state == IDLE);
    assign busy     = (state == SHIFT);

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        remain_nxt  = remain;
        window_nxt  = window;
        fill_nxt    = fill;
        pattern_nxt = pattern;
        thresh_nxt  = thresh;
        cnt_nxt     = match_cnt;
        irq_nxt     = irq;
        cfg_err_nxt = 1'b0;
        match_fire  = 1'b0;
        win_shift   = {window[2:0], shreg[WORD_W-1]};
        fill_inc    = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
        cnt_inc     = (&match_cnt) ? match_cnt : match_cnt + 1'b1;

        if (clr) begin
            // pattern and thresh deliberately survive a soft clear
            state_nxt  = IDLE;
            remain_nxt = '0;
            window_nxt = '0;
            fill_nxt   = '0;
            cnt_nxt    = '0;
            irq_nxt    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        pattern_nxt = cfg_pattern;
                        thresh_nxt  = cfg_thresh;
                    end
                    if (in_valid) begin
                        shreg_nxt  = in_data;
                        remain_nxt = WORD_LD;
                        state_nxt  = SHIFT;
                    end
                end
                SHIFT: begin
                    cfg_err_nxt = cfg_we;
                    shreg_nxt   = {shreg[WORD_W-2:0], 1'b0};
                    window_nxt  = win_shift;
                    fill_nxt    = fill_inc;
                    remain_nxt  = remain - 1'b1;
                    match_fire  = (win_shift == pattern) && (fill_inc == 3'd4);
                    if (remain == CW'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            endcase

            if (match_fire) begin
                cnt_nxt = cnt_inc;
            end
            if (irq_clr) begin
                irq_nxt = 1'b0;
            end
            // a threshold crossing overrides a simultaneous clear
            if (match_fire && (thresh != '0) && (cnt_inc >= thresh)) begin
                irq_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            remain      <= '0;
            window      <= '0;
            fill        <= '0;
            pattern     <= 4'b1001;
            thresh      <= CNT_W'(1);
            match_cnt   <= '0;
            irq         <= 1'b0;
            match_pulse <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            remain      <= remain_nxt;
            window      <= window_nxt;
            fill        <= fill_nxt;
            pattern     <= pattern_nxt;
            thresh      <= thresh_nxt;
            match_cnt   <= cnt_nxt;
            irq         <= irq_nxt;
            match_pulse <= match_fire;
            cfg_err     <= cfg_err_nxt;
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: hand-computed per-shift masks of
// match_pulse, irq, cfg_err and in_ready for each scanned word.
module tb_seq_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, clr, cfg_we, in_valid, irq_clr;
    logic [3:0] cfg_pattern;
    logic [7:0] cfg_thresh, in_data;
    logic       in_ready, busy, match_pulse, irq, cfg_err;
    logic [7:0] match_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] mp, irqm, errm, rdym;

    seq_scan_ctrl #(.WORD_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .cfg_we(cfg_we),
        .cfg_pattern(cfg_pattern), .cfg_thresh(cfg_thresh),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .busy(busy), .match_pulse(match_pulse), .match_cnt(match_cnt),
        .irq(irq), .irq_clr(irq_clr), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic do_cfg(input logic [3:0] p, input logic [7:0] t);
        cfg_pattern = p;
        cfg_thresh  = t;
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
    endtask

    // Offers one word and records outputs after each of the 8 shift edges.
    // *_at selects the shift edge (1..8) coinciding with clr / cfg_we / irq_clr.
    task automatic send(input logic [7:0] d, input int clr_at, input int cfg_at,
                        input int iclr_at, input logic cfg_hs,
                        output logic [7:0] o_mp, output logic [7:0] o_irq,
                        output logic [7:0] o_err, output logic [7:0] o_rdy);
        o_mp = '0; o_irq = '0; o_err = '0; o_rdy = '0;
        for (int k = 0; k < 20 && !in_ready; k++) tick();
        check("ready_before_word", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = d;
        cfg_we   = cfg_hs;
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check("busy_after_handshake", {in_ready, busy}, 2'b01);
        for (int s = 1; s <= 8; s++) begin
            clr     = (s == clr_at);
            cfg_we  = (s == cfg_at);
            irq_clr = (s == iclr_at);
            tick();
            clr = 1'b0; cfg_we = 1'b0; irq_clr = 1'b0;
            o_mp[s-1]  = match_pulse;
            o_irq[s-1] = irq;
            o_err[s-1] = cfg_err;
            o_rdy[s-1] = in_ready;
            if (s == clr_at) break;
        end
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; irq_clr = 1'b0;
        cfg_pattern = 4'b0000; cfg_thresh = 8'd0; in_data = 8'd0;

        do_rst();
        check("reset_ready_busy", {in_ready, busy}, 2'b10);
        check("reset_cnt", match_cnt, 8'd0);
        check("reset_irq", irq, 1'b0);
        check("reset_pulses", {match_pulse, cfg_err}, 2'b00);

        // 0x99 with default pattern 1001, thresh 1
        send(8'h99, 0, 0, 0, 1'b0, mp, irqm, errm, rdym);
        check("w99_match_pulse", mp, 8'h88);
        check("w99_irq", irqm, 8'hF8);
        check("w99_ready", rdym, 8'h80);
        check("w99_cnt", match_cnt, 8'd2);

        // overlapping matches
        do_clr();
        check("clr_cnt", match_cnt, 8'd0);
        check("clr_irq", irq, 1'b0);
        send(8'h92, 0, 0, 0, 1'b0, mp, irqm, errm, rdym);
        check("w92_match_pulse", mp, 8'h48);
        check("w92_cnt", match_cnt, 8'd2);

        // match spanning a word boundary
        do_clr();
        send(8'h01, 0, 0, 0, 1'b0, mp, irqm, errm, rdym);
        check("w01_match_pulse", mp, 8'h00);
        send(8'h20, 0, 0, 0, 1'b0, mp, irqm, errm, rdym);
        check("w20_match_pulse", mp, 8'h04);
        check("w01_20_cnt", match_cnt, 8'd1);

        // pattern 0000, thresh 5
        do_cfg(4'b0000, 8'd5);
        do_clr();
        send(8'h00, 0, 0, 0, 1'b0, mp, irqm, errm, rdym);
        check("w00_match_pulse", mp, 8'hF8);
        check("w00_irq", irqm, 8'h80);
        check("w00_cnt", match_cnt, 8'd5);

        // cfg_we while shifting is rejected
        do_rst();
        cfg_pattern = 4'b0000;
        cfg_thresh  = 8'd7;
        send(8'h00, 0, 3, 0, 1'b0, mp, irqm, errm, rdym);
        check("busy_cfg_err", errm, 8'h04);
        check("busy_cfg_pattern_kept", mp, 8'h00);
        check("busy_cfg_cnt", match_cnt, 8'd0);

        // irq_clr on the crossing edge loses to the set
        send(8'h99, 0, 0, 4, 1'b0, mp, irqm, errm, rdym);
        check("set_beats_clr_irq", irqm, 8'hF8);
        check("set_beats_clr_mp", mp, 8'h88);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("irq_clr", irq, 1'b0);

        // clr at shift 5 aborts the word
        do_rst();
        send(8'h99, 5, 0, 0, 1'b0, mp, irqm, errm, rdym);
        check("clr_mid_mp", mp, 8'h08);
        check("clr_mid_state", {in_ready, busy}, 2'b10);
        check("clr_mid_cnt", match_cnt, 8'd0);
        check("clr_mid_irq", irq, 1'b0);
        send(8'h09, 0, 0, 0, 1'b0, mp, irqm, errm, rdym);
        check("w09_after_clr_mp", mp, 8'h80);
        check("w09_after_clr_cnt", match_cnt, 8'd1);

        // cfg_we with the handshake applies to that word
        do_rst();
        cfg_pattern = 4'b1111;
        cfg_thresh  = 8'd1;
        send(8'h0F, 0, 0, 0, 1'b1, mp, irqm, errm, rdym);
        check("hs_cfg_mp", mp, 8'h80);
        check("hs_cfg_err", errm, 8'h00);

        // thresh 0 never raises irq
        do_cfg(4'b1001, 8'd0);
        do_clr();
        send(8'h99, 0, 0, 0, 1'b0, mp, irqm, errm, rdym);
        check("thresh0_irq", irqm, 8'h00);
        check("thresh0_cnt", match_cnt, 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, input word width (>=4).
REQ-002 SHALL have parameter CNT_W, default 8, match counter and threshold width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port clr  input  1  synchronous soft clear of the stream and statistics.
REQ-006 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-007 SHALL have port cfg_pattern  input  4  pattern to detect; window[3] is compared with pattern[3].
REQ-008 SHALL have port cfg_thresh  input  CNT_W  match count that raises irq.
REQ-009 SHALL have port in_valid  input  1  word offered.
REQ-010 SHALL have port in_data  input  WORD_W  word to scan, serialized MSB first.
REQ-011 SHALL have port in_ready  output  1  controller can accept a word; equals (state==IDLE).
REQ-012 SHALL have port busy  output  1  equals (state==SHIFT).
REQ-013 SHALL have port match_pulse  output  1  registered one-cycle pulse per match.
REQ-014 SHALL have port match_cnt  output  CNT_W  saturating match count.
REQ-015 SHALL have port irq  output  1  sticky threshold flag.
REQ-016 SHALL have port irq_clr  input  1  clears irq.
REQ-017 SHALL have port cfg_err  output  1  registered one-cycle pulse when cfg_we arrives while busy.

Function
REQ-018 SHALL implement FSM states IDLE and SHIFT: IDLE->SHIFT on in_valid&&in_ready (word captured); SHIFT->IDLE after WORD_W shift edges.
REQ-019 SHALL shift exactly one bit per clock in SHIFT, MSB first: window <= {window[2:0], bit}, where the handshake edge is N and the bits shift on edges N+1..N+WORD_W.
REQ-020 SHALL hold in_ready low during SHIFT and raise it in the cycle after edge N+WORD_W, giving one word per WORD_W+1 cycles.
REQ-021 SHALL keep window and a fill counter (saturating at 4) across words, so matches may span word boundaries.
REQ-022 SHALL flag a match on a shift edge when the next window equals pattern and the next fill equals 4; overlapping matches all count.
REQ-023 SHALL assert match_pulse on the edge where the matching bit is shifted, visible for exactly one cycle.
REQ-024 SHALL increment match_cnt on the same edge as the match and saturate at 2^CNT_W-1.
REQ-025 SHALL set irq on the edge where match_cnt becomes >= thresh while thresh != 0; thresh==0 never sets irq.
REQ-026 SHALL clear irq on irq_clr; if set and clear occur on the same edge, set wins.
REQ-027 SHALL load pattern and thresh on cfg_we only in IDLE; in SHIFT, cfg_we SHALL be ignored and SHALL pulse cfg_err.
REQ-028 SHALL treat cfg_we coincident with a handshake in IDLE as accepted, so the new pattern applies to that word.
REQ-029 SHALL, on clr, zero window, fill, match_cnt and irq and force IDLE, discarding any word mid-shift; pattern and thresh are kept.
REQ-030 SHALL apply priority rst > clr > normal operation.

Reset
REQ-031 SHALL, on rst, set state=IDLE (in_ready=1, busy=0), window=0, fill=0, match_cnt=0, irq=0, match_pulse=0, cfg_err=0, pattern=4'b1001, thresh=1.
REQ-032 SHALL let rst mid-SHIFT abort the word, with no match_pulse on that edge.

Verification
REQ-033 SHALL verify: after reset, send 0x99 -> match_pulse on shift edges 4 and 8; match_cnt=2; irq=1 after edge 4; in_ready back after 9 cycles.
REQ-034 SHALL verify: send 0x92 -> overlapping matches on shift edges 4 and 7; match_cnt=2.
REQ-035 SHALL verify: send 0x01 then 0x20 -> single cross-word match on the third shift of the second word; match_cnt=1.
REQ-036 SHALL verify: cfg pattern=0000, thresh=5, then send 0x00 -> 5 matches (shifts 4-8), no match on shifts 1-3; irq set on shift 8.
REQ-037 SHALL verify: cfg_we during SHIFT -> cfg_err one-cycle pulse and pattern unchanged; irq_clr coincident with the threshold crossing -> irq stays 1.
REQ-038 SHALL verify: clr asserted at shift 5 of 0x99 -> IDLE next cycle, match_cnt=0, and the next 0x09 gives no match until fill reaches 4.
